// File: rtl/char_page_buffer_pkg.sv
// rtl/char_page_buffer_pkg.sv - shared character constants and FSM state types for the page buffer
package char_page_buffer_pkg;

    localparam logic [7:0] CHAR_SPACE = 8'h20;

    typedef enum logic {
        FLIP_IDLE,
        FLIP_PEND
    } flip_state_t;

    typedef enum logic {
        CLR_IDLE,
        CLR_RUN
    } clr_state_t;

endpackage

// File: rtl/char_clear_engine.sv
// rtl/char_clear_engine.sv - background page clear, one cell per cycle in ascending order
module char_clear_engine
    import char_page_buffer_pkg::*;
#(
    parameter int NCH = 64,
    parameter int AW  = 6,
    parameter int PW  = 1
) (
    input  logic          SYSCLK_IP,
    input  logic          CPU_RESETN_IP,
    input  logic          start,
    input  logic [PW-1:0] start_page,
    output logic          busy,
    output logic          clr_we,
    output logic [PW-1:0] clr_page,
    output logic [AW-1:0] clr_addr
);

    clr_state_t    state_q, state_n;
    logic [AW-1:0] cnt_q, cnt_n;
    logic [PW-1:0] page_q, page_n;

    always_ff @(posedge SYSCLK_IP) begin
        if (!CPU_RESETN_IP) begin
            state_q <= CLR_IDLE;
            cnt_q   <= '0;
            page_q  <= '0;
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
            page_q  <= page_n;
        end
    end

    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        page_n  = page_q;
        case (state_q)
            CLR_IDLE: begin
                if (start) begin
                    state_n = CLR_RUN;
                    cnt_n   = '0;
                    page_n  = start_page;
                end
            end
            CLR_RUN: begin
                cnt_n = cnt_q + 1'b1;
                if (cnt_q == AW'(NCH - 1)) begin
                    state_n = CLR_IDLE;
                    cnt_n   = '0;
                end
            end
            default: state_n = CLR_IDLE;
        endcase
    end

    assign busy     = (state_q == CLR_RUN);
    assign clr_we   = busy;
    assign clr_page = page_q;
    assign clr_addr = cnt_q;

endmodule

// File: rtl/char_page_buffer.sv
// rtl/char_page_buffer.sv - multi-page character frame buffer with frame-synchronous page flip and clear
module char_page_buffer
    import char_page_buffer_pkg::*;
#(
    parameter int  COLS  = 16,
    parameter int  ROWS  = 4,
    parameter int  PAGES = 2,
    parameter int  CW    = 8,
    localparam int NCH   = ROWS * COLS,
    localparam int AW    = $clog2(NCH),
    localparam int PW    = (PAGES > 1) ? $clog2(PAGES) : 1
) (
    input  logic              SYSCLK_IP,
    input  logic              CPU_RESETN_IP,
    input  logic              WE_IP,
    input  logic [PW-1:0]     WRITE_PAGE_IP,
    input  logic [AW-1:0]     WRITE_ADDR_IP,
    input  logic [CW-1:0]     WRITE_DATA_IP,
    input  logic              FLIP_REQ_IP,
    input  logic [PW-1:0]     FLIP_PAGE_IP,
    input  logic              CLR_REQ_IP,
    input  logic [PW-1:0]     CLR_PAGE_IP,
    input  logic              PRINT_FIN_IP,
    output logic [NCH*CW-1:0] CHAR_DATA_OP,
    output logic [PW-1:0]     DISP_PAGE_OP,
    output logic              FLIP_PEND_OP,
    output logic              BUSY_OP,
    output logic              ERR_OP
);

    localparam logic [PW:0]   PAGE_LIMIT = (PW+1)'(PAGES);
    localparam logic [AW:0]   ADDR_LIMIT = (AW+1)'(NCH);
    localparam logic [CW-1:0] SPACE      = CW'(CHAR_SPACE);

    logic [PAGES-1:0][NCH-1:0][CW-1:0] mem_q;
    logic [NCH*CW-1:0] char_q;
    flip_state_t       flip_q, flip_n;
    logic [PW-1:0]     target_q, target_n, disp_q, disp_n;
    logic              err_q;
    logic              wr_ok, wr_err, flip_ok, clr_ok, clr_start, clr_err;
    logic              busy, clr_we;
    logic [PW-1:0]     clr_page;
    logic [AW-1:0]     clr_addr;

    assign wr_ok     = WE_IP && ({1'b0, WRITE_PAGE_IP} < PAGE_LIMIT)
                             && ({1'b0, WRITE_ADDR_IP} < ADDR_LIMIT);
    assign wr_err    = WE_IP && !wr_ok;
    assign flip_ok   = ({1'b0, FLIP_PAGE_IP} < PAGE_LIMIT);
    assign clr_ok    = ({1'b0, CLR_PAGE_IP} < PAGE_LIMIT);
    assign clr_start = CLR_REQ_IP && clr_ok && !busy;
    assign clr_err   = CLR_REQ_IP && !clr_start;

    char_clear_engine #(
        .NCH (NCH),
        .AW  (AW),
        .PW  (PW)
    ) u_clear (
        .SYSCLK_IP     (SYSCLK_IP),
        .CPU_RESETN_IP (CPU_RESETN_IP),
        .start         (clr_start),
        .start_page    (CLR_PAGE_IP),
        .busy          (busy),
        .clr_we        (clr_we),
        .clr_page      (clr_page),
        .clr_addr      (clr_addr)
    );

    // A PRINT_FIN commits only what was already pending; a same-edge request becomes the next pending flip.
    always_comb begin
        flip_n   = flip_q;
        target_n = target_q;
        disp_n   = disp_q;
        case (flip_q)
            FLIP_IDLE: flip_n = FLIP_IDLE;
            FLIP_PEND: begin
                if (PRINT_FIN_IP) begin
                    disp_n = target_q;
                    flip_n = FLIP_IDLE;
                end
            end
            default: flip_n = FLIP_IDLE;
        endcase
        if (FLIP_REQ_IP && flip_ok) begin
            target_n = FLIP_PAGE_IP;
            flip_n   = FLIP_PEND;
        end
    end

    always_ff @(posedge SYSCLK_IP) begin
        if (!CPU_RESETN_IP) begin
            mem_q    <= {(PAGES*NCH){SPACE}};
            char_q   <= {NCH{SPACE}};
            flip_q   <= FLIP_IDLE;
            target_q <= '0;
            disp_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            // Host write is issued last so it overrides a clear of the same cell.
            if (clr_we) mem_q[clr_page][clr_addr] <= SPACE;
            if (wr_ok)  mem_q[WRITE_PAGE_IP][WRITE_ADDR_IP] <= WRITE_DATA_IP;
            char_q   <= mem_q[disp_q];
            flip_q   <= flip_n;
            target_q <= target_n;
            disp_q   <= disp_n;
            err_q    <= err_q | wr_err | clr_err | (FLIP_REQ_IP && !flip_ok);
        end
    end

    assign CHAR_DATA_OP = char_q;
    assign DISP_PAGE_OP = disp_q;
    assign FLIP_PEND_OP = (flip_q == FLIP_PEND);
    assign BUSY_OP      = busy;
    assign ERR_OP       = err_q;

endmodule

// File: doc/char_page_buffer.md
Name: char_page_buffer

Overview:
- Parametrised, multi-page character frame buffer feeding the OLED controller's flattened character input.
- Replaces the single fixed 64-char buffer with PAGES independent ROWSxCOLS pages and a host write port addressed by page.
- Adds tear-free page flipping, committed only at the controller's frame boundary (print-finish pulse), and a background page-clear engine.
- Sits between the host/CPU write interface and oled_ctrl inside the display top.

Parameters:
- COLS, 16, characters per row
- ROWS, 4, rows per page
- PAGES, 2, number of pages (>=2)
- CW, 8, bits per character code
- NCH, ROWS*COLS, derived: cells per page
- AW, $clog2(NCH), derived: cell address width
- PW, $clog2(PAGES), derived: page index width (min 1)

Ports:
- SYSCLK_IP  in  1  system clock, all logic on rising edge
- CPU_RESETN_IP  in  1  reset, synchronous, active-low
- WE_IP  in  1  host write strobe, one cell per cycle
- WRITE_PAGE_IP  in  PW  target page of write
- WRITE_ADDR_IP  in  AW  cell index = row*COLS+col
- WRITE_DATA_IP  in  CW  character code
- FLIP_REQ_IP  in  1  pulse: request display of FLIP_PAGE_IP
- FLIP_PAGE_IP  in  PW  requested display page
- CLR_REQ_IP  in  1  pulse: fill CLR_PAGE_IP with space
- CLR_PAGE_IP  in  PW  page to clear
- PRINT_FIN_IP  in  1  frame-done pulse from oled_ctrl
- CHAR_DATA_OP  out  NCH*CW  displayed page, cell i at [i*CW +: CW]
- DISP_PAGE_OP  out  PW  page currently displayed
- FLIP_PEND_OP  out  1  flip request latched, not yet committed
- BUSY_OP  out  1  clear engine active
- ERR_OP  out  1  sticky error flag

Behaviour:
- Reset, synchronous on CPU_RESETN_IP low at an edge:
  - All cells of all pages = CHAR_SPACE (0x20); CHAR_DATA_OP all 0x20.
  - DISP_PAGE_OP = 0; FLIP_PEND_OP = 0; BUSY_OP = 0; ERR_OP = 0.
  - Reset mid-clear or mid-flip aborts both; no partial state survives.
- Write:
  - WE_IP at edge t updates the cell at t. If the cell is on the displayed page, CHAR_DATA_OP reflects it after edge t+1 (output is registered: 2-edge latency).
  - Page >= PAGES or address >= NCH: write dropped, ERR_OP set.
- Flip FSM, states IDLE/PEND:
  - IDLE + FLIP_REQ_IP with valid page: latch target, go PEND, FLIP_PEND_OP = 1.
  - PEND + FLIP_REQ_IP: target overwritten, remain PEND.
  - PEND + PRINT_FIN_IP: commit only if the request was latched on an earlier edge. DISP_PAGE_OP <= target, back to IDLE; CHAR_DATA_OP shows the new page one edge later.
  - FLIP_REQ_IP and PRINT_FIN_IP on the same edge from IDLE: latch only, commit at the next PRINT_FIN_IP.
  - Invalid flip page: ignored, ERR_OP set.
  - Flip to a page being cleared is allowed; the display shows clear progress.
- Clear engine, states IDLE/CLR:
  - CLR_REQ_IP in IDLE with valid page: BUSY_OP = 1 from the next edge.
  - Writes 0x20 to cells 0..NCH-1, one per cycle, ascending. BUSY_OP deasserts after exactly NCH cycles.
  - CLR_REQ_IP while BUSY_OP: ignored, ERR_OP set.
  - Host writes are accepted during a clear. If a host write and a clear hit the same cell on the same edge, the host write wins.
- ERR_OP clears only on reset.

Decomposition:
- Shared package/include (char_def, state_def):
  - CHAR_SPACE = 8'h20
  - Flip states FLIP_IDLE, FLIP_PEND
  - Clear states CLR_IDLE, CLR_RUN
- Sub-module char_clear_engine: AW-bit cell counter, BUSY, and per-cycle (page, addr, we) outputs, muxed with host-write priority in the parent.

Test Plan:
- Reset, then write page0 addr5 = 0x41 -> CHAR_DATA_OP[47:40] = 0x41 two edges later; all other cells 0x20; DISP_PAGE_OP = 0.
- Write page1 addr0 = 0x42; FLIP_REQ page1 -> FLIP_PEND_OP = 1, CHAR_DATA_OP unchanged. PRINT_FIN pulse 10 cycles later -> DISP_PAGE_OP = 1, FLIP_PEND_OP = 0, CHAR_DATA_OP[7:0] = 0x42 next edge.
- FLIP_REQ and PRINT_FIN on the same edge -> no commit; second PRINT_FIN -> commit. Two FLIP_REQs (page1 then page0) before PRINT_FIN -> page0 displayed.
- Fill page0 with 0x58, then CLR_REQ page0 -> BUSY_OP high for exactly 64 cycles, then all cells 0x20. Host write addr63 = 0x5A on the engine's final cycle -> addr63 = 0x5A.
- CLR_REQ during BUSY_OP -> ignored, ERR_OP = 1; it stays 1 until CPU_RESETN_IP low. Reset mid-clear -> BUSY_OP = 0 and all pages 0x20.
- PAGES=3 build: WRITE_PAGE_IP = 3 -> write dropped, ERR_OP = 1; FLIP_PAGE_IP = 3 -> FLIP_PEND_OP stays 0.
